// File: rtl/rtsnoc_tx_arbiter.sv
// Round-robin TX arbiter for one RTSNoC router local port: grants one client,
// latches (and optionally origin-stamps) its flit, then issues a single wr_o pulse.

// Per-client flit formatter: keeps the bus-sized part of the flit, zeroes the
// unused upper bits and optionally overwrites the origin fields.
module rtsnoc_flit_fmt #(
  parameter int TX_ADDR        = 0,
  parameter int TX_ADDR_X      = 0,
  parameter int TX_ADDR_Y      = 0,
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int STAMP_ORIG     = 1
) (
  input  logic [37:0] flit_i,
  output logic [37:0] flit_o
);
  localparam int NBS    = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6;
  localparam int ORIG_W = SOC_SIZE_X + SOC_SIZE_Y + 3;
  localparam logic [ORIG_W-1:0] ORIG =
    {SOC_SIZE_X'(TX_ADDR_X), SOC_SIZE_Y'(TX_ADDR_Y), 3'(TX_ADDR)};

  always_comb begin
    flit_o          = '0;
    flit_o[NBS-1:0] = flit_i[NBS-1:0];
    if (STAMP_ORIG != 0) flit_o[NBS-1 -: ORIG_W] = ORIG;
  end
endmodule

module rtsnoc_tx_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int CLIENT_IDX_W   = 2,
  parameter int TX_ADDR        = 0,
  parameter int TX_ADDR_X      = 0,
  parameter int TX_ADDR_Y      = 0,
  parameter int SOC_SIZE_X     = 1,
  parameter int SOC_SIZE_Y     = 1,
  parameter int NOC_DATA_WIDTH = 16,
  parameter int STAMP_ORIG     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_CLIENTS-1:0]    tx_req_i,
  input  logic [38*NUM_CLIENTS-1:0] tx_flit_i,
  output logic [NUM_CLIENTS-1:0]    tx_ack_o,
  output logic [NUM_CLIENTS-1:0]    grant_o,
  output logic                      busy_o,
  output logic [37:0]               din_o,
  output logic                      wr_o,
  input  logic                      wait_i
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, WRITE = 2'd2} state_e;

  localparam logic [CLIENT_IDX_W:0]   NC   = (CLIENT_IDX_W+1)'(NUM_CLIENTS);
  localparam logic [CLIENT_IDX_W-1:0] LAST = CLIENT_IDX_W'(NUM_CLIENTS-1);

  state_e                        state_q, state_d;
  logic [CLIENT_IDX_W-1:0]       ptr_q, ptr_d;
  logic [37:0]                   din_q, din_d;
  logic [NUM_CLIENTS-1:0]        ack_q, ack_d, grant_q, grant_d;
  logic                          wr_q, wr_d;
  logic [NUM_CLIENTS-1:0][37:0]  flit_fmt;
  logic                          found;
  logic [CLIENT_IDX_W-1:0]       win;
  logic [CLIENT_IDX_W:0]         idx;

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_fmt
    rtsnoc_flit_fmt #(
      .TX_ADDR(TX_ADDR), .TX_ADDR_X(TX_ADDR_X), .TX_ADDR_Y(TX_ADDR_Y),
      .SOC_SIZE_X(SOC_SIZE_X), .SOC_SIZE_Y(SOC_SIZE_Y),
      .NOC_DATA_WIDTH(NOC_DATA_WIDTH), .STAMP_ORIG(STAMP_ORIG)
    ) u_fmt (
      .flit_i(tx_flit_i[38*k +: 38]),
      .flit_o(flit_fmt[k])
    );
  end

  // First requester at or above ptr, wrapping modulo NUM_CLIENTS.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = {1'b0, ptr_q} + (CLIENT_IDX_W+1)'(i);
      if (idx >= NC) idx = idx - NC;
      if (!found && tx_req_i[idx[CLIENT_IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[CLIENT_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    din_d   = din_q;
    ack_d   = '0;
    grant_d = grant_q;
    wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          din_d        = flit_fmt[win];
          ack_d[win]   = 1'b1;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          ptr_d        = (win == LAST) ? '0 : win + 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (!wait_i) begin
          wr_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        din_d   = '0;
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
    end
  end

  assign tx_ack_o = ack_q;
  assign grant_o  = grant_q;
  assign din_o    = din_q;
  assign wr_o     = wr_q;
  assign busy_o   = (state_q == WAIT) || (state_q == WRITE);
endmodule

// File: tb/tb_rtsnoc_tx_arbiter.sv
// Bench for rtsnoc_tx_arbiter: a stamping and a pass-through instance share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_rtsnoc_tx_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [38*N-1:0]   flit = '0;
  logic              wait_i = 1'b0;
  logic [N-1:0]      ack0, grant0, ack1, grant1;
  logic              busy0, busy1, wr0, wr1;
  logic [37:0]       din0, din1;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int grant_log[$];
  int wr_cyc[$];

  always #5 clk = ~clk;

  rtsnoc_tx_arbiter #(
    .NUM_CLIENTS(4), .CLIENT_IDX_W(2), .TX_ADDR(3), .TX_ADDR_X(0), .TX_ADDR_Y(1),
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .NOC_DATA_WIDTH(16), .STAMP_ORIG(1)
  ) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .tx_req_i(req), .tx_flit_i(flit),
    .tx_ack_o(ack0), .grant_o(grant0), .busy_o(busy0), .din_o(din0),
    .wr_o(wr0), .wait_i(wait_i)
  );

  rtsnoc_tx_arbiter #(
    .NUM_CLIENTS(4), .CLIENT_IDX_W(2), .TX_ADDR(3), .TX_ADDR_X(0), .TX_ADDR_Y(1),
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .NOC_DATA_WIDTH(16), .STAMP_ORIG(0)
  ) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .tx_req_i(req), .tx_flit_i(flit),
    .tx_ack_o(ack1), .grant_o(grant1), .busy_o(busy1), .din_o(din1),
    .wr_o(wr1), .wait_i(wait_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Field-level header rebuild: origin (0,1,3) when stamping, bits above 25 dropped.
  function automatic logic [37:0] fmt(input logic [37:0] f, input bit stamp);
    logic [37:0] r;
    r        = '0;
    r[15:0]  = f[15:0];
    r[18:16] = f[18:16];
    r[19]    = f[19];
    r[20]    = f[20];
    r[23:21] = stamp ? 3'd3 : f[23:21];
    r[24]    = stamp ? 1'b1 : f[24];
    r[25]    = stamp ? 1'b0 : f[25];
    return r;
  endfunction

  // Transaction model: a grant, then a write once wait_i is seen low, then a gap cycle.
  int          m_phase = 0;
  int          m_ptr   = 0;
  logic [N-1:0] e_ack = '0, e_grant = '0;
  logic        e_wr = 1'b0;
  logic [37:0] e_din0 = '0, e_din1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; e_ack = '0; e_grant = '0; e_wr = 1'b0;
      e_din0 = '0; e_din1 = '0;
    end else begin
      int k;
      k = -1;
      e_ack = '0;
      if (m_phase == 0) begin
        for (int i = 0; i < N; i++)
          if (k < 0 && req[(m_ptr + i) % N]) k = (m_ptr + i) % N;
        if (k >= 0) begin
          e_ack[k]   = 1'b1;
          e_grant    = '0;
          e_grant[k] = 1'b1;
          e_din0     = fmt(flit[k*38 +: 38], 1'b1);
          e_din1     = fmt(flit[k*38 +: 38], 1'b0);
          m_ptr      = (k + 1) % N;
          m_phase    = 1;
        end
      end else if (m_phase == 1) begin
        if (!wait_i) begin e_wr = 1'b1; m_phase = 2; end
      end else begin
        e_wr = 1'b0; e_grant = '0; m_phase = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    chk("ack",   64'(ack0),   64'(e_ack));
    chk("grant", 64'(grant0), 64'(e_grant));
    chk("wr",    64'(wr0),    64'(e_wr));
    chk("busy",  64'(busy0),  64'(m_phase != 0));
    chk("din",   64'(din0),   64'(e_din0));
    chk("din_pass", 64'(din1), 64'(e_din1));
    chk("wr_pass",  64'(wr1),  64'(e_wr));
    if (wr0) wr_cyc.push_back(cyc);
    for (int i = 0; i < N; i++) if (ack0[i]) grant_log.push_back(i);
  end

  task automatic set_flit(input int c, input logic [37:0] v);
    flit[c*38 +: 38] = v;
  endtask

  initial begin
    int exp_ord[6];
    logic [63:0] r;
    logic [37:0] f3;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    for (int c = 0; c < N; c++) begin
      r = {$urandom(), $urandom()};
      set_flit(c, r[37:0]);
    end

    // Reset held with every client requesting
    req = '1;
    repeat (3) @(negedge clk);
    chk("rst_wr",    64'(wr0),    64'h0);
    chk("rst_ack",   64'(ack0),   64'h0);
    chk("rst_grant", 64'(grant0), 64'h0);
    chk("rst_din",   64'(din0),   64'h0);
    chk("rst_busy",  64'(busy0),  64'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("first_ack",   64'(ack0),   64'h1);
    chk("first_grant", 64'(grant0), 64'h1);
    @(posedge clk); #2;
    chk("first_wr",      64'(wr0),  64'h1);
    chk("first_ack_off", 64'(ack0), 64'h0);
    repeat (16) @(posedge clk);
    #2;
    chk("rr_count", 64'(grant_log.size() >= 6), 64'h1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("rr_order", 64'(grant_log[i]), 64'(exp_ord[i]));
    chk("wr_count", 64'(wr_cyc.size() >= 5), 64'h1);
    for (int i = 1; i < 5 && i < wr_cyc.size(); i++)
      chk("wr_period", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd3);

    // Single client 2 with a stamped header
    @(negedge clk); rst_n = 1'b0; req = '0;
    @(negedge clk); rst_n = 1'b1;
    grant_log.delete(); wr_cyc.delete();
    set_flit(2, 38'h00_01500AB);
    req = 4'b0100;
    @(posedge clk); #2;
    chk("c2_ack", 64'(ack0), 64'h4);
    chk("c2_din", 64'(din0), 64'h17500AB);
    @(negedge clk); req = '0;
    repeat (6) @(posedge clk);
    #2;
    chk("c2_wr_once",  64'(wr_cyc.size()),    64'd1);
    chk("c2_ack_once", 64'(grant_log.size()), 64'd1);

    // Back-pressure held for 10 cycles
    @(negedge clk);
    wait_i = 1'b1;
    r = {$urandom(), $urandom()};
    f3 = r[37:0];
    set_flit(3, f3);
    req = 4'b1000;
    @(posedge clk); #2;
    chk("bp_ack", 64'(ack0), 64'h8);
    @(negedge clk); req = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("bp_wr_low", 64'(wr0),   64'h0);
      chk("bp_busy",   64'(busy0), 64'h1);
      chk("bp_din",    64'(din0),  64'(fmt(f3, 1'b1)));
    end
    @(negedge clk); wait_i = 1'b0;
    @(posedge clk); #2;
    chk("bp_wr_pulse", 64'(wr0), 64'h1);
    @(posedge clk); #2;
    chk("bp_wr_end", 64'(wr0),    64'h0);
    chk("bp_gnt_end", 64'(grant0), 64'h0);

    // Reset in WAIT under back-pressure; the request is served again afterwards
    @(negedge clk); wait_i = 1'b1; req = 4'b0100;
    @(posedge clk); #2;
    chk("ar_ack", 64'(ack0), 64'h4);
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    chk("ar_grant", 64'(grant0), 64'h0);
    chk("ar_din",   64'(din0),   64'h0);
    chk("ar_busy",  64'(busy0),  64'h0);
    chk("ar_wr",    64'(wr0),    64'h0);
    @(negedge clk); rst_n = 1'b1; wait_i = 1'b0;
    wr_cyc.delete();
    @(posedge clk); #2;
    chk("ar_regrant", 64'(ack0), 64'h4);
    @(negedge clk); req = '0;
    repeat (5) @(posedge clk);
    #2;
    chk("ar_wr_once", 64'(wr_cyc.size()), 64'd1);

    // Pass-through header with garbage above bit 25
    @(negedge clk);
    set_flit(1, {12'hABC, 26'h3EA1234});
    req = 4'b0010;
    @(posedge clk); #2;
    chk("pt_ack",   64'(ack1), 64'h2);
    chk("pt_din",   64'(din1), 64'h3EA1234);
    chk("st_din",   64'(din0), 64'h16A1234);
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (!req[c] && $urandom_range(0, 1) == 0) begin
          r = {$urandom(), $urandom()};
          set_flit(c, r[37:0]);
        end
        req[c] = ($urandom_range(0, 2) == 0);
      end
      wait_i = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk); req = '0; wait_i = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
